mod_74x86_arb: RTL and testbench
================================

MOD_74X86_ARB -- requirements
Module: mod_74x86_arb

Interface
REQ-001: Parameter W, default 4, SHALL set the operand/result width of the shared XOR unit (one 74x86 gate per bit).
REQ-002: Parameter N, fixed at 4, SHALL set the number of requesters; the ports below are sized for N=4.
REQ-003: CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004: CLR_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005: REQ  input  4  SHALL carry the per-requester request; bit i = requester i.
REQ-006: A  input  4*W  SHALL carry the packed A operands; slice i = bits [i*W +: W].
REQ-007: B  input  4*W  SHALL carry the packed B operands with the same packing as A.
REQ-008: GNT  output  4  SHALL be the one-hot grant, registered.
REQ-009: ACK  output  4  SHALL be the one-hot, single-cycle completion strobe, registered.
REQ-010: Y  output  W  SHALL carry the last result, registered, held until overwritten.
REQ-011: BUSY  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012: OPCNT  output  8  SHALL count completed operations.

Function
REQ-013: The FSM SHALL have exactly three states, IDLE, EXEC and DONE, and SHALL return to IDLE from any illegal encoding.
REQ-014: IDLE: with no REQ bit set, the FSM SHALL remain in IDLE with GNT=0.
REQ-015: IDLE: with any REQ bit set, the next edge SHALL select the winner k, latch A[k] and B[k] into internal registers, set GNT to one-hot k, and enter EXEC.
REQ-016: Winner selection SHALL be round-robin: search from requester (LAST+1) mod 4 upward with wrap-around, where LAST is the last served index.
REQ-017: EXEC: the next edge SHALL load Y with the latched A XOR the latched B, set ACK to one-hot k, increment OPCNT, update LAST to k, and enter DONE.
REQ-018: DONE: ACK SHALL be high for this single cycle; the next edge SHALL clear GNT and ACK and enter IDLE.
REQ-019: Latency SHALL be fixed: REQ sampled at edge 0, GNT high after edge 0, Y valid and ACK high after edge 1, return to IDLE after edge 2; peak throughput is one operation per 3 cycles.
REQ-020: Handshake: a requester SHALL hold REQ and its operands until it samples ACK, then drop REQ at that same edge.
REQ-021: Operand changes after the latch edge SHALL NOT affect Y.
REQ-022: A REQ still high in IDLE after its ACK SHALL be treated as a new request.
REQ-023: REQ changes during EXEC or DONE SHALL be ignored until IDLE.
REQ-024: A non-granted requester's REQ SHALL stay pending, without loss, across any number of arbitration rounds.
REQ-025: OPCNT SHALL wrap from 255 to 0 with no flag.
REQ-026: GNT and ACK SHALL never have more than one bit set.
REQ-027: ACK SHALL only ever be set for the currently granted index.

Reset
REQ-028: CLR_n low SHALL immediately force state=IDLE, GNT=0, ACK=0, Y=0, BUSY=0, OPCNT=0 and LAST=3, so requester 0 has first priority.
REQ-029: Reset asserted mid-operation (EXEC or DONE) SHALL abort the operation without an ACK; the requester re-arbitrates after release.
REQ-030: The first rising edge after CLR_n rises SHALL be able to sample REQ.

Verification
REQ-031: Single request: W=4, REQ=0001, A0=1111, B0=1010 -> GNT=0001 after edge 0; Y=0101 with ACK=0001 after edge 1; IDLE and OPCNT=1 after edge 2.
REQ-032: All four requesters held continuously from reset -> served in order 0,1,2,3,0 with ACK one-hot every 3 cycles; OPCNT=5 after the fifth ACK.
REQ-033: Round-robin fairness: after requester 2 is served, REQ=0101 -> requester 0 is granted (search 3 -> 0), then requester 2.
REQ-034: Operand stability: A1 changed from 0011 to 1100 during EXEC, B1=0000 -> Y=0011.
REQ-035: Reset mid-EXEC: CLR_n pulsed low during EXEC -> GNT=ACK=Y=OPCNT=0 at once and no ACK pulse; after release, requester 0 has priority.
REQ-036: Wrap-around: 256 completed operations -> OPCNT=0; XOR truth table 1^1=0, 0^1=1, 1^0=1, 0^0=0 holds on every bit.

Source files
------------

// File: rtl/mod_74x86_arb.sv
// Round-robin arbiter sharing one W-bit 74x86-style XOR unit among four requesters.
// Each operation takes three cycles: grant/latch, execute/acknowledge, release.
module mod_74x86_arb #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 4
) (
  input  logic           CLK,
  input  logic           CLR_n,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] A,
  input  logic [N*W-1:0] B,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   ACK,
  output logic [W-1:0]   Y,
  output logic           BUSY,
  output logic [7:0]     OPCNT
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [IW-1:0]   last;
  logic [IW-1:0]   last_nx;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   sel_nx;
  logic [W-1:0]    a_lat;
  logic [W-1:0]    a_lat_nx;
  logic [W-1:0]    b_lat;
  logic [W-1:0]    b_lat_nx;
  logic [W-1:0]    xor_res;
  logic [N-1:0]    gnt_nx;
  logic [N-1:0]    ack_nx;
  logic [W-1:0]    y_nx;
  logic [7:0]      opcnt_nx;
  logic            busy_nx;

  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;

  // One XOR gate per bit of the latched operands
  for (genvar g = 0; g < W; g++) begin : g_xor
    assign xor_res[g] = a_lat[g] ^ b_lat[g];
  end

  // Round-robin search starting just after the last served requester
  always_comb begin
    win   = last;
    cand  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last) + i) % N);
      if (!found && REQ[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; illegal encodings fall back to IDLE
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = found ? EXEC : IDLE;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    gnt_nx   = GNT;
    ack_nx   = ACK;
    y_nx     = Y;
    opcnt_nx = OPCNT;
    last_nx  = last;
    sel_nx   = sel;
    a_lat_nx = a_lat;
    b_lat_nx = b_lat;
    busy_nx  = (state_nx != IDLE);
    case (state)
      IDLE: begin
        gnt_nx = '0;
        ack_nx = '0;
        if (found) begin
          gnt_nx   = N'(1) << win;
          sel_nx   = win;
          a_lat_nx = A[32'(win)*W +: W];
          b_lat_nx = B[32'(win)*W +: W];
        end
      end
      EXEC: begin
        y_nx     = xor_res;
        ack_nx   = GNT;
        opcnt_nx = OPCNT + 8'd1;
        last_nx  = sel;
      end
      DONE: begin
        gnt_nx = '0;
        ack_nx = '0;
      end
      default: begin
        gnt_nx = '0;
        ack_nx = '0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      GNT   <= '0;
      ACK   <= '0;
      Y     <= '0;
      BUSY  <= 1'b0;
      OPCNT <= 8'd0;
      last  <= IW'(N - 1);
      sel   <= '0;
      a_lat <= '0;
      b_lat <= '0;
    end else begin
      GNT   <= gnt_nx;
      ACK   <= ack_nx;
      Y     <= y_nx;
      BUSY  <= busy_nx;
      OPCNT <= opcnt_nx;
      last  <= last_nx;
      sel   <= sel_nx;
      a_lat <= a_lat_nx;
      b_lat <= b_lat_nx;
    end
  end

endmodule

// File: tb/tb_mod_74x86_arb.sv
// Directed bench for the shared-XOR round-robin arbiter.
module tb_mod_74x86_arb;

  logic        clk;
  logic        clr_n;
  logic [3:0]  req;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  y;
  logic        busy;
  logic [7:0]  opcnt;

  int nvec;
  int nmis;

  mod_74x86_arb #(.W(4), .N(4)) dut (
    .CLK   (clk),
    .CLR_n (clr_n),
    .REQ   (req),
    .A     (a),
    .B     (b),
    .GNT   (gnt),
    .ACK   (ack),
    .Y     (y),
    .BUSY  (busy),
    .OPCNT (opcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it misses
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation starting from an IDLE negedge
  task automatic run_op(input string tag, input logic [3:0] req_v, input logic [15:0] a_v,
                        input logic [15:0] b_v, input logic [15:0] a_mid, input logic [3:0] req_mid,
                        input logic [3:0] req_end, input int k, input logic [3:0] y_exp,
                        input logic [7:0] cnt_exp);
    req = req_v;
    a   = a_v;
    b   = b_v;
    @(posedge clk); @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_noack"}, 32'(ack), 32'd0);
    a   = a_mid;
    req = req_mid;
    @(posedge clk); @(negedge clk);
    chk({tag, "_ack"}, 32'(ack), 32'(1 << k));
    chk({tag, "_y"}, 32'(y), 32'(y_exp));
    chk({tag, "_cnt"}, 32'(opcnt), 32'(cnt_exp));
    req = req_end;
    @(posedge clk); @(negedge clk);
    chk({tag, "_gnt0"}, 32'(gnt), 32'd0);
    chk({tag, "_ack0"}, 32'(ack), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] av;
    logic [3:0] bv;
    nvec  = 0;
    nmis  = 0;
    clr_n = 1'b0;
    req   = 4'h0;
    a     = 16'h0;
    b     = 16'h0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(opcnt), 32'd0);
    clr_n = 1'b1;

    // Single request: 1111 ^ 1010 = 0101
    run_op("single", 4'b0001, 16'h000F, 16'h000A, 16'h000F, 4'b0001, 4'b0000, 0, 4'h5, 8'd1);

    // All four held from reset: order 0,1,2,3,0
    @(negedge clk);
    clr_n = 1'b0;
    req   = 4'hF;
    a     = 16'h4321;
    b     = 16'hCCCC;
    @(negedge clk);
    clr_n = 1'b1;
    run_op("all0", 4'hF, 16'h4321, 16'hCCCC, 16'h4321, 4'hF, 4'hF, 0, 4'hD, 8'd1);
    run_op("all1", 4'hF, 16'h4321, 16'hCCCC, 16'h4321, 4'hF, 4'hF, 1, 4'hE, 8'd2);
    run_op("all2", 4'hF, 16'h4321, 16'hCCCC, 16'h4321, 4'hF, 4'hF, 2, 4'hF, 8'd3);
    run_op("all3", 4'hF, 16'h4321, 16'hCCCC, 16'h4321, 4'hF, 4'hF, 3, 4'h8, 8'd4);
    run_op("all4", 4'hF, 16'h4321, 16'hCCCC, 16'h4321, 4'hF, 4'h0, 0, 4'hD, 8'd5);
    chk("all_cnt5", 32'(opcnt), 32'd5);

    // Fairness: serve 2, then 0101 goes to 0 first, 2 stays pending
    run_op("rr2", 4'b0100, 16'h0906, 16'h0503, 16'h0906, 4'b0100, 4'b0000, 2, 4'hC, 8'd6);
    run_op("rr0", 4'b0101, 16'h0906, 16'h0503, 16'h0906, 4'b0101, 4'b0100, 0, 4'h5, 8'd7);
    run_op("rr2b", 4'b0100, 16'h0906, 16'h0503, 16'h0906, 4'b0100, 4'b0000, 2, 4'hC, 8'd8);

    // Operand change and REQ change during EXEC are ignored
    run_op("stab", 4'b0010, 16'h0030, 16'h0000, 16'h00C0, 4'b1010, 4'b0000, 1, 4'h3, 8'd9);
    @(posedge clk); @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Truth table on every bit: 1100 ^ 1010 = 0110
    run_op("truth", 4'b0001, 16'h000C, 16'h000A, 16'h000C, 4'b0001, 4'b0000, 0, 4'h6, 8'd10);

    // Reset pulsed during EXEC aborts without ACK
    req = 4'b0010;
    a   = 16'h0057;
    b   = 16'h0034;
    @(posedge clk); @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h2);
    clr_n = 1'b0;
    req   = 4'b0011;
    #1;
    chk("abort_gnt0", 32'(gnt), 32'd0);
    chk("abort_ack0", 32'(ack), 32'd0);
    chk("abort_y0", 32'(y), 32'd0);
    chk("abort_cnt0", 32'(opcnt), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("abort_noack", 32'(ack), 32'd0);
    clr_n = 1'b1;
    run_op("post0", 4'b0011, 16'h0057, 16'h0034, 16'h0057, 4'b0011, 4'b0010, 0, 4'h3, 8'd1);
    run_op("post1", 4'b0010, 16'h0057, 16'h0034, 16'h0057, 4'b0010, 4'b0000, 1, 4'h6, 8'd2);

    // 256 operations wrap the counter to zero
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      av = 4'(i);
      bv = 4'(i >> 4);
      run_op("wrap", 4'b0001, {12'h0, av}, {12'h0, bv}, {12'h0, av}, 4'b0001,
             (i == 255) ? 4'b0000 : 4'b0001, 0, av ^ bv, 8'(i + 1));
    end
    chk("wrap_cnt0", 32'(opcnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
